// File: rtl/apb_irq_pkg.sv
// Shared definitions for the APB interrupt controller: register offsets,
// the interrupt id type and the fixed-priority encoder.
package apb_irq_pkg;

  localparam logic [2:0] IER_OFS  = 3'h0;
  localparam logic [2:0] IPR_OFS  = 3'h1;
  localparam logic [2:0] ITR_OFS  = 3'h2;
  localparam logic [2:0] IVR_OFS  = 3'h3;
  localparam logic [2:0] ISWR_OFS = 3'h4;

  typedef logic [2:0] irq_id_t;

  // Returns {valid, id}; the lowest set index wins, {0, 0} when nothing is set.
  function automatic logic [3:0] prio_enc(input logic [7:0] vec);
    logic [3:0] res;
    res = 4'h0;
    // Scan downwards so the lowest set index is written last.
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        res = {1'b1, irq_id_t'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_irq_ctrl_irq_src_detect.sv
// Per-source pending-set detector.
// Optional macro IRQ_CTRL_SYNC_EN: adds a 2-flop synchronizer in front of detection.
// Ports:
//   pclk      clock
//   preset    synchronous reset, active-high
//   src       raw interrupt flag
//   edge_mode 1 = rising-edge detect, 0 = level
//   set_req   request to set the pending bit this cycle
module irq_src_detect (
  input  logic pclk,
  input  logic preset,
  input  logic src,
  input  logic edge_mode,
  output logic set_req
);

  logic samp_s;
  logic hist_r;

`ifdef IRQ_CTRL_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-flop synchronizer for sources asynchronous to pclk.
  always_ff @(posedge pclk) begin
    if (preset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= src;
      sync2_r <= sync1_r;
    end
  end

  assign samp_s = sync2_r;
`else
  assign samp_s = src;
`endif

  // Edge history; clears to 0 so a source high at reset release is seen as a rising edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      hist_r <= 1'b0;
    end else begin
      hist_r <= samp_s;
    end
  end

  // Level or rising-edge select.
  always_comb begin
    if (edge_mode) begin
      set_req = samp_s & ~hist_r;
    end else begin
      set_req = samp_s;
    end
  end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: pending/enable/type registers, software trigger,
// fixed-priority resolution and registered irq/irq_id outputs.
// Optional macro IRQ_CTRL_SYNC_EN (in irq_src_detect): synchronizes irq_src.
// Ports:
//   pclk, preset                     clock and synchronous active-high reset
//   psel, penable, pwrite, paddr,
//   pwdata, prdata, pready, pslverr  APB slave port (zero wait states)
//   irq_src                          raw interrupt flags, src 0 = highest priority
//   irq, irq_id                      interrupt request and winning source index
module apb_irq_ctrl
  import apb_irq_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [7:0]            prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [NUM_SRC-1:0]    irq_src,
  output logic                  irq,
  output logic [2:0]            irq_id
);

  localparam logic [8:0] MASK_WIDE = (9'd1 << NUM_SRC) - 9'd1;
  localparam logic [7:0] SRC_MASK  = MASK_WIDE[7:0];

  logic               access_s;
  logic [2:0]         ofs_s;
  logic               err_s;
  logic               wr_s;
  logic               rd_s;
  logic [7:0]         wdata_s;
  logic [NUM_SRC-1:0] set_req_s;
  logic [7:0]         set_vec_s;
  logic [7:0]         w1c_s;
  logic [7:0]         swr_s;
  logic [7:0]         rdata_s;
  logic [3:0]         prio_s;
  logic               unused_s;

  logic [7:0] ier_r;
  logic [7:0] ipr_r;
  logic [7:0] itr_r;
  logic       irq_r;
  irq_id_t    irq_id_r;

  assign access_s  = psel & penable;
  assign ofs_s     = paddr[2:0];
  assign wdata_s   = pwdata[7:0];
  assign err_s     = access_s & ((ofs_s > ISWR_OFS) | (pwrite & (ofs_s == IVR_OFS)));
  assign wr_s      = access_s & pwrite & ~err_s;
  assign rd_s      = access_s & ~pwrite & ~err_s & ~preset;
  assign set_vec_s = 8'(set_req_s);
  assign prio_s    = prio_enc(ipr_r & ier_r);
  assign unused_s  = ^{paddr[ADDR_WIDTH-1:3], pwdata[31:8]};

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    irq_src_detect u_det (
      .pclk      (pclk),
      .preset    (preset),
      .src       (irq_src[gi]),
      .edge_mode (itr_r[gi]),
      .set_req   (set_req_s[gi])
    );
  end

  // Decode W1C clear and software-set masks from the current write.
  always_comb begin
    w1c_s = 8'h00;
    swr_s = 8'h00;
    if (wr_s && (ofs_s == IPR_OFS)) begin
      w1c_s = wdata_s;
    end else begin
      w1c_s = 8'h00;
    end
    if (wr_s && (ofs_s == ISWR_OFS)) begin
      swr_s = wdata_s;
    end else begin
      swr_s = 8'h00;
    end
  end

  // Register read mux.
  always_comb begin
    rdata_s = 8'h00;
    case (ofs_s)
      IER_OFS:  rdata_s = ier_r;
      IPR_OFS:  rdata_s = ipr_r;
      ITR_OFS:  rdata_s = itr_r;
      IVR_OFS:  rdata_s = {irq_r, 4'b0000, irq_id_r};
      default:  rdata_s = 8'h00;
    endcase
  end

  // Register file and output registers; set terms are OR-ed after the clear so set wins.
  always_ff @(posedge pclk) begin
    if (preset) begin
      ier_r    <= 8'h00;
      ipr_r    <= 8'h00;
      itr_r    <= 8'h00;
      irq_r    <= 1'b0;
      irq_id_r <= 3'd0;
    end else begin
      if (wr_s && (ofs_s == IER_OFS)) begin
        ier_r <= wdata_s & SRC_MASK;
      end
      if (wr_s && (ofs_s == ITR_OFS)) begin
        itr_r <= wdata_s & SRC_MASK;
      end
      ipr_r    <= ((ipr_r & ~w1c_s) | set_vec_s | swr_s) & SRC_MASK;
      irq_r    <= prio_s[3];
      irq_id_r <= prio_s[2:0];
    end
  end

  // APB responses are gated by reset so an aborted transfer reports nothing.
  assign pready  = access_s & ~preset;
  assign pslverr = err_s & ~preset;
  assign prdata  = rd_s ? rdata_s : 8'h00;
  assign irq     = irq_r;
  assign irq_id  = irq_id_r;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
module tb_apb_irq_ctrl;

  localparam int NSRC = 6;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [7:0]  prdata;
  logic        pready, pslverr;
  logic [NSRC-1:0] irq_src;
  logic        irq;
  logic [2:0]  irq_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  apb_irq_ctrl #(.NUM_SRC(NSRC), .ADDR_WIDTH(12)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .irq_src(irq_src), .irq(irq), .irq_id(irq_id)
  );

  task automatic apb_write(input logic [11:0] a, input logic [7:0] d,
                           output logic err, output logic rdy);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = {24'hABCDEF, d};
    @(negedge pclk);
    penable = 1'b1;
    #1;
    err = pslverr; rdy = pready;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [7:0] d,
                          output logic err, output logic rdy);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    d = prdata; err = pslverr; rdy = pready;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d; logic e, r;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h000; pwdata = 32'h0; irq_src = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk); preset = 1'b0;
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", irq); end
    n_cmp++; if (irq_id !== 3'd0) begin n_err++; $display("FAIL reset_irq_id got %0d exp 0", irq_id); end
    n_cmp++; if (pready !== 1'b0) begin n_err++; $display("FAIL idle_pready got %b exp 0", pready); end
    for (int a = 0; a < 5; a++) begin
      apb_read(12'(a), d, e, r);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_rd%0d got %h exp 00", a, d); end
      n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL reset_err%0d got %b exp 0", a, e); end
      n_cmp++; if (r !== 1'b1) begin n_err++; $display("FAIL reset_rdy%0d got %b exp 1", a, r); end
    end
  endtask

  task automatic test_edge;
    logic [7:0] d; logic e, r;
    apb_write(12'h000, 8'h01, e, r);
    apb_write(12'h002, 8'h01, e, r);
    @(negedge pclk); irq_src[0] = 1'b1;
    @(negedge pclk); irq_src[0] = 1'b0;
    @(negedge pclk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_irq got %b exp 1", irq); end
    apb_read(12'h003, d, e, r);
    n_cmp++; if (d !== 8'h80) begin n_err++; $display("FAIL edge_ivr got %h exp 80", d); end
    apb_read(12'h001, d, e, r);
    n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL edge_ipr got %h exp 01", d); end
    apb_write(12'h001, 8'h01, e, r);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL clr_irq_lat got %b exp 1", irq); end
    @(posedge pclk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL clr_irq got %b exp 0", irq); end
    apb_read(12'h001, d, e, r);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL clr_ipr got %h exp 00", d); end
  endtask

  task automatic test_level;
    logic [7:0] d; logic e, r;
    apb_write(12'h002, 8'h00, e, r);
    apb_write(12'h000, 8'h02, e, r);
    @(negedge pclk); irq_src[1] = 1'b1;
    repeat (2) @(negedge pclk);
    apb_read(12'h003, d, e, r);
    n_cmp++; if (d !== 8'h81) begin n_err++; $display("FAIL lvl_ivr got %h exp 81", d); end
    apb_write(12'h001, 8'h02, e, r);
    apb_read(12'h001, d, e, r);
    n_cmp++; if (d !== 8'h02) begin n_err++; $display("FAIL lvl_setwins got %h exp 02", d); end
    @(negedge pclk); irq_src[1] = 1'b0;
    apb_write(12'h001, 8'h02, e, r);
    apb_read(12'h001, d, e, r);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL lvl_clr got %h exp 00", d); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_irq got %b exp 0", irq); end
  endtask

  task automatic test_swr_prio;
    logic [7:0] d; logic e, r;
    apb_write(12'h000, 8'h0C, e, r);
    apb_write(12'h004, 8'h0C, e, r);
    apb_read(12'h003, d, e, r);
    n_cmp++; if (d !== 8'h82) begin n_err++; $display("FAIL swr_ivr2 got %h exp 82", d); end
    n_cmp++; if (irq_id !== 3'd2) begin n_err++; $display("FAIL swr_id2 got %0d exp 2", irq_id); end
    apb_read(12'h004, d, e, r);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL iswr_rd got %h exp 00", d); end
    apb_write(12'h001, 8'h04, e, r);
    apb_read(12'h003, d, e, r);
    n_cmp++; if (d !== 8'h83) begin n_err++; $display("FAIL swr_ivr3 got %h exp 83", d); end
    apb_write(12'h001, 8'h08, e, r);
    apb_read(12'h003, d, e, r);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL swr_ivr0 got %h exp 00", d); end
  endtask

  task automatic test_errors;
    logic [7:0] d; logic e, r;
    apb_write(12'h005, 8'hFF, e, r);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL err_wr5 got %b exp 1", e); end
    n_cmp++; if (r !== 1'b1) begin n_err++; $display("FAIL err_rdy got %b exp 1", r); end
    apb_read(12'h100, d, e, r);
    n_cmp++; if (d !== 8'h0C) begin n_err++; $display("FAIL err_ier got %h exp 0C", d); end
    apb_read(12'h001, d, e, r);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL err_ipr got %h exp 00", d); end
    apb_write(12'h003, 8'hFF, e, r);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL err_wrivr got %b exp 1", e); end
    apb_read(12'h003, d, e, r);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL err_ivr got %h exp 00", d); end
    apb_read(12'h007, d, e, r);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL err_rd7 got %h exp 00", d); end
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL err_rd7e got %b exp 1", e); end
    apb_write(12'h000, 8'hFF, e, r);
    apb_read(12'h000, d, e, r);
    n_cmp++; if (d !== 8'h3F) begin n_err++; $display("FAIL ier_mask got %h exp 3F", d); end
    apb_write(12'h004, 8'hC0, e, r);
    apb_read(12'h001, d, e, r);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL swr_mask got %h exp 00", d); end
    apb_write(12'h000, 8'h00, e, r);
  endtask

  task automatic test_mask_reset;
    logic [7:0] d; logic e, r;
    apb_write(12'h002, 8'h01, e, r);
    @(negedge pclk); irq_src[0] = 1'b1;
    @(negedge pclk); irq_src[0] = 1'b0;
    apb_read(12'h001, d, e, r);
    n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL mask_ipr got %h exp 01", d); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_irq got %b exp 0", irq); end
    apb_write(12'h000, 8'h01, e, r);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL unmask_lat got %b exp 0", irq); end
    @(posedge pclk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL unmask_irq got %b exp 1", irq); end
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h3F;
    @(negedge pclk);
    penable = 1'b1; preset = 1'b1;
    #1;
    n_cmp++; if (pready !== 1'b0) begin n_err++; $display("FAIL rst_pready got %b exp 0", pready); end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk); preset = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b exp 0", irq); end
    for (int a = 0; a < 3; a++) begin
      apb_read(12'(a), d, e, r);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL rst_rd%0d got %h exp 00", a, d); end
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_swr_prio();
    test_errors();
    test_mask_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
